sd_host_regif: RTL and testbench

Host-bus register interface that sits directly upstream of the SD host core.
- Decodes CPU accesses on the addrs/wr_data/rd_data bus and holds the SD host's software-visible registers.
- Merges hardware status updates (present state, response, interrupt set pulses) from the CMD/DAT/DMA stages.
- Emits a one-cycle command-start pulse and a level interrupt.
- Registers and bit positions use SD Host Controller standard offsets.

---
 rtl/sd_host_regif_pkg.sv | 28 ++
 rtl/sd_w1c_reg16.sv | 20 ++
 rtl/sd_host_regif.sv | 171 +++++++++++++++++
 tb/tb_sd_host_regif.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_host_regif_pkg.sv
// Shared definitions for the SD host register interface: register byte offsets,
// access FSM states, present-state bit positions and a byte-lane helper.
package sd_host_regif_pkg;

    localparam logic [12:0] OFS_BLK     = 13'h004;
    localparam logic [12:0] OFS_ARG     = 13'h008;
    localparam logic [12:0] OFS_CMD     = 13'h00C;
    localparam logic [12:0] OFS_RESP    = 13'h010;
    localparam logic [12:0] OFS_PSR     = 13'h024;
    localparam logic [12:0] OFS_BGC     = 13'h028;
    localparam logic [12:0] OFS_INT     = 13'h030;
    localparam logic [12:0] OFS_INTEN   = 13'h034;
    localparam logic [12:0] OFS_ADMA_LO = 13'h058;
    localparam logic [12:0] OFS_ADMA_HI = 13'h05C;

    localparam int PSR_CMD_INHIBIT = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    // Expands 4 byte enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/sd_w1c_reg16.sv
// 16-bit write-1-to-clear status register; a set pulse wins over a clear of the same bit.
// Latency: set/clear visible one cycle after the edge they are sampled on.
// Backpressure: none, updates every cycle.
module sd_w1c_reg16 (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [15:0] set,
    input  logic [15:0] clr,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            q <= '0;
        end else begin
            q <= (q & ~clr) | set;
        end
    end

endmodule

// File: rtl/sd_host_regif.sv
// CPU register file for the SD host core with hardware status merge and interrupt output.
// Latency: req to one-cycle ack is 1 cycle; back-to-back accesses take 2 cycles each.
// Backpressure: req is held by the host until ack; req is ignored during the ack cycle.
module sd_host_regif
    import sd_host_regif_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              rst_L,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addrs,
    input  logic [3:0]        be,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              bus_err,
    input  logic [31:0]       psr_in,
    input  logic [31:0]       resp_in,
    input  logic              resp_we,
    input  logic [15:0]       nisr_set,
    input  logic [15:0]       eisr_set,
    output logic [15:0]       blk_size,
    output logic [15:0]       blk_cnt,
    output logic [31:0]       arg,
    output logic [15:0]       xfer_mode,
    output logic [15:0]       cmd,
    output logic [15:0]       bgc,
    output logic [63:0]       adma_addr,
    output logic              cmd_start,
    output logic              irq
);

    state_t              state_q;
    state_t              state_d;
    logic                accept;

    logic [ADDR_W-3:0]   addr_word;
    logic                hit;
    logic                cmd_locked;
    logic                err;
    logic                wr_ok;
    logic                int_wr;
    logic [31:0]         rdat;
    logic [31:0]         wmask;
    logic [31:0]         wmerge;

    logic [31:0]         resp_q;
    logic [15:0]         nisr;
    logic [15:0]         eisr;
    logic [15:0]         nisr_en;
    logic [15:0]         eisr_en;
    logic [15:0]         nisr_clr;
    logic [15:0]         eisr_clr;

    assign addr_word = addrs[ADDR_W-1:2];

    always_ff @(posedge CLK) begin
        if (!rst_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ACK;
                    accept  = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ack = (state_q == ST_ACK);

    // Read mux doubles as the "old value" source for byte-lane merging on writes.
    always_comb begin
        hit  = 1'b1;
        rdat = '0;
        case (addr_word)
            OFS_BLK[12:2]:     rdat = {blk_cnt, blk_size};
            OFS_ARG[12:2]:     rdat = arg;
            OFS_CMD[12:2]:     rdat = {cmd, xfer_mode};
            OFS_RESP[12:2]:    rdat = resp_q;
            OFS_PSR[12:2]:     rdat = psr_in;
            OFS_BGC[12:2]:     rdat = {bgc, 16'h0000};
            OFS_INT[12:2]:     rdat = {eisr, nisr};
            OFS_INTEN[12:2]:   rdat = {eisr_en, nisr_en};
            OFS_ADMA_LO[12:2]: rdat = adma_addr[31:0];
            OFS_ADMA_HI[12:2]: rdat = adma_addr[63:32];
            default:           hit  = 1'b0;
        endcase
    end

    assign wmask  = lane_mask(be);
    assign wmerge = (rdat & ~wmask) | (wr_data & wmask);

    // A command write while the CMD line is busy is rejected as a whole word.
    assign cmd_locked = we && (addr_word == OFS_CMD[12:2]) && (be[3:2] != 2'b00)
                        && psr_in[PSR_CMD_INHIBIT];
    assign err        = !hit || (addrs[1:0] != 2'b00) || cmd_locked;
    assign wr_ok      = accept && we && !err;
    assign int_wr     = wr_ok && (addr_word == OFS_INT[12:2]);
    assign nisr_clr   = int_wr ? (wr_data[15:0]  & wmask[15:0])  : 16'h0000;
    assign eisr_clr   = int_wr ? (wr_data[31:16] & wmask[31:16]) : 16'h0000;

    sd_w1c_reg16 u_nisr (
        .clk   (CLK),
        .rst_L (rst_L),
        .set   (nisr_set),
        .clr   (nisr_clr),
        .q     (nisr)
    );

    sd_w1c_reg16 u_eisr (
        .clk   (CLK),
        .rst_L (rst_L),
        .set   (eisr_set),
        .clr   (eisr_clr),
        .q     (eisr)
    );

    always_ff @(posedge CLK) begin
        if (!rst_L) begin
            blk_size  <= '0;
            blk_cnt   <= '0;
            arg       <= '0;
            xfer_mode <= '0;
            cmd       <= '0;
            bgc       <= '0;
            adma_addr <= '0;
            nisr_en   <= '0;
            eisr_en   <= '0;
            resp_q    <= '0;
            rd_data   <= '0;
            bus_err   <= 1'b0;
            cmd_start <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (resp_we) begin
                resp_q <= resp_in;
            end
            if (wr_ok) begin
                case (addr_word)
                    OFS_BLK[12:2]:     {blk_cnt, blk_size}  <= wmerge;
                    OFS_ARG[12:2]:     arg                  <= wmerge;
                    OFS_CMD[12:2]:     {cmd, xfer_mode}     <= wmerge;
                    OFS_BGC[12:2]:     bgc                  <= wmerge[31:16];
                    OFS_INTEN[12:2]:   {eisr_en, nisr_en}   <= wmerge;
                    OFS_ADMA_LO[12:2]: adma_addr[31:0]      <= wmerge;
                    OFS_ADMA_HI[12:2]: adma_addr[63:32]     <= wmerge;
                    default:           ;
                endcase
            end
            rd_data   <= (accept && !err) ? rdat : '0;
            bus_err   <= accept && err;
            cmd_start <= wr_ok && (addr_word == OFS_CMD[12:2]) && be[3];
            irq       <= ((nisr & nisr_en) != 16'h0000) || ((eisr & eisr_en) != 16'h0000);
        end
    end

endmodule

// File: tb/tb_sd_host_regif.sv
// Directed bench for sd_host_regif: a word-map model keyed by byte address is checked
// against every DUT output each cycle, plus literal expectations per scenario.
module tb_sd_host_regif;

    logic        CLK = 1'b0;
    logic        rst_L = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [12:0] addrs = '0;
    logic [3:0]  be = '0;
    logic [31:0] wr_data = '0;
    logic        ack;
    logic [31:0] rd_data;
    logic        bus_err;
    logic [31:0] psr_in = '0;
    logic [31:0] resp_in = '0;
    logic        resp_we = 1'b0;
    logic [15:0] nisr_set = '0;
    logic [15:0] eisr_set = '0;
    logic [15:0] blk_size;
    logic [15:0] blk_cnt;
    logic [31:0] arg;
    logic [15:0] xfer_mode;
    logic [15:0] cmd;
    logic [15:0] bgc;
    logic [63:0] adma_addr;
    logic        cmd_start;
    logic        irq;

    always #5 CLK = ~CLK;

    sd_host_regif dut (
        .CLK       (CLK),
        .rst_L     (rst_L),
        .req       (req),
        .we        (we),
        .addrs     (addrs),
        .be        (be),
        .wr_data   (wr_data),
        .ack       (ack),
        .rd_data   (rd_data),
        .bus_err   (bus_err),
        .psr_in    (psr_in),
        .resp_in   (resp_in),
        .resp_we   (resp_we),
        .nisr_set  (nisr_set),
        .eisr_set  (eisr_set),
        .blk_size  (blk_size),
        .blk_cnt   (blk_cnt),
        .arg       (arg),
        .xfer_mode (xfer_mode),
        .cmd       (cmd),
        .bgc       (bgc),
        .adma_addr (adma_addr),
        .cmd_start (cmd_start),
        .irq       (irq)
    );

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: software-visible words keyed by byte address; a missing key is unmapped.
    localparam logic [12:0] MAP [10] = '{13'h004, 13'h008, 13'h00C, 13'h010, 13'h024,
                                         13'h028, 13'h030, 13'h034, 13'h058, 13'h05C};
    logic [31:0] mreg [logic [12:0]];
    logic        m_inack = 1'b0;
    logic        e_ack, e_err, e_cs, e_irq;
    logic [31:0] e_rd;

    always @(posedge CLK) begin : model_p
        logic [31:0] m;
        logic [31:0] clr;
        logic [31:0] v;
        logic        err;
        if (!rst_L) begin
            mreg.delete();
            foreach (MAP[i]) mreg[MAP[i]] = '0;
            m_inack = 1'b0;
            e_ack = 1'b0; e_err = 1'b0; e_cs = 1'b0; e_irq = 1'b0; e_rd = '0;
        end else begin
            clr   = '0;
            e_irq = ((mreg[13'h030] & mreg[13'h034]) != 32'h0);
            e_ack = 1'b0; e_rd = '0; e_err = 1'b0; e_cs = 1'b0;
            if (m_inack) begin
                m_inack = 1'b0;
            end else if (req) begin
                m_inack = 1'b1;
                e_ack   = 1'b1;
                err = (addrs[1:0] != 2'b00) || !mreg.exists(addrs) ||
                      (we && addrs == 13'h00C && be[3:2] != 2'b00 && psr_in[0]);
                e_err = err;
                if (!err) begin
                    e_rd = (addrs == 13'h024) ? psr_in : mreg[addrs];
                    if (we) begin
                        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                        if (addrs == 13'h030) begin
                            clr = wr_data & m;
                        end else if (addrs != 13'h010 && addrs != 13'h024) begin
                            v = mreg[addrs];
                            v = (v & ~m) | (wr_data & m);
                            if (addrs == 13'h028) v = v & 32'hFFFF_0000;
                            mreg[addrs] = v;
                        end
                        e_cs = (addrs == 13'h00C) && be[3];
                    end
                end
            end
            if (resp_we) mreg[13'h010] = resp_in;
            mreg[13'h030] = (mreg[13'h030] & ~clr) | {eisr_set, nisr_set};
        end
    end

    always @(negedge CLK) begin : cmp_p
        logic [31:0] w4, w8, wc, w28, w58, w5c;
        if (cmp_en) begin
            w4  = mreg[13'h004];
            w8  = mreg[13'h008];
            wc  = mreg[13'h00C];
            w28 = mreg[13'h028];
            w58 = mreg[13'h058];
            w5c = mreg[13'h05C];
            chk("ack",       64'(ack),       64'(e_ack));
            chk("rd_data",   64'(rd_data),   64'(e_rd));
            chk("bus_err",   64'(bus_err),   64'(e_err));
            chk("cmd_start", 64'(cmd_start), 64'(e_cs));
            chk("irq",       64'(irq),       64'(e_irq));
            chk("blk_size",  64'(blk_size),  64'(w4[15:0]));
            chk("blk_cnt",   64'(blk_cnt),   64'(w4[31:16]));
            chk("arg",       64'(arg),       64'(w8));
            chk("xfer_mode", 64'(xfer_mode), 64'(wc[15:0]));
            chk("cmd",       64'(cmd),       64'(wc[31:16]));
            chk("bgc",       64'(bgc),       64'(w28[31:16]));
            chk("adma_addr", adma_addr,      {w5c, w58});
        end
    end

    logic [31:0] last_rd;
    logic        last_err;
    logic        last_cs;
    logic [15:0] nset_req = '0;

    task automatic access(input logic w, input logic [12:0] a, input logic [3:0] b,
                          input logic [31:0] d);
        int n;
        n = 0;
        @(negedge CLK);
        req = 1'b1; we = w; addrs = a; be = b; wr_data = d; nisr_set = nset_req;
        do begin
            @(negedge CLK);
            nisr_set = '0;
            n++;
        end while (!ack && n < 8);
        chk("ack_latency", 64'(n), 64'd1);
        last_rd  = rd_data;
        last_err = bus_err;
        last_cs  = cmd_start;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [12:0] a);
        access(1'b0, a, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [12:0] a, input logic [3:0] b, input logic [31:0] d);
        access(1'b1, a, b, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        psr_in = 32'h0000_00A5;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        rst_L  = 1'b1;
        cmp_en = 1'b1;
        chk("reset_ack", 64'(ack), 64'd0);
        chk("reset_irq", 64'(irq), 64'd0);

        // Reads after reset
        rd(13'h030); chk("rd_int0", 64'(last_rd), 64'h0); chk("rd_int0_err", 64'(last_err), 64'd0);
        rd(13'h008); chk("rd_arg0", 64'(last_rd), 64'h0);
        rd(13'h024); chk("rd_psr",  64'(last_rd), 64'h0000_00A5);

        // Byte-lane writes to block size/count
        wr(13'h004, 4'b0011, 32'h0003_0200);
        chk("blk_size_lo", 64'(blk_size), 64'h0200);
        chk("blk_cnt_lo",  64'(blk_cnt),  64'h0000);
        wr(13'h004, 4'hF, 32'h0003_0200);
        chk("blk_cnt_all", 64'(blk_cnt), 64'h0003);

        // Command write with and without cmd_inhibit
        psr_in = 32'h0000_00A4;
        wr(13'h00C, 4'hF, 32'h1100_0023);
        chk("cmd_cs",   64'(last_cs),   64'd1);
        chk("cmd_val",  64'(cmd),       64'h1100);
        chk("xfer_val", 64'(xfer_mode), 64'h0023);
        psr_in = 32'h0000_00A5;
        wr(13'h00C, 4'hF, 32'h2200_0045);
        chk("cmd_lock_err", 64'(last_err),  64'd1);
        chk("cmd_lock_cs",  64'(last_cs),   64'd0);
        chk("cmd_lock_cmd", 64'(cmd),       64'h1100);
        chk("cmd_lock_xm",  64'(xfer_mode), 64'h0023);
        wr(13'h00C, 4'b0011, 32'h0000_0031);
        chk("xm_only_err", 64'(last_err),  64'd0);
        chk("xm_only_val", 64'(xfer_mode), 64'h0031);

        // Normal interrupt: set, set-priority W1C, clear
        wr(13'h034, 4'hF, 32'h0000_0001);
        @(negedge CLK); nisr_set = 16'h0001;
        @(negedge CLK); nisr_set = 16'h0000; chk("irq_lag", 64'(irq), 64'd0);
        @(negedge CLK); chk("irq_set", 64'(irq), 64'd1);
        nset_req = 16'h0001;
        wr(13'h030, 4'hF, 32'h0000_0001);
        nset_req = 16'h0000;
        rd(13'h030); chk("w1c_setprio", 64'(last_rd), 64'h1); chk("irq_hold", 64'(irq), 64'd1);
        wr(13'h030, 4'hF, 32'h0000_0001);
        rd(13'h030); chk("w1c_clr", 64'(last_rd), 64'h0); chk("irq_clr", 64'(irq), 64'd0);

        // Error interrupt with its enable off
        @(negedge CLK); eisr_set = 16'h8000;
        @(negedge CLK); eisr_set = 16'h0000;
        rd(13'h030); chk("eisr_set", 64'(last_rd), 64'h8000_0000); chk("eisr_noirq", 64'(irq), 64'd0);
        wr(13'h030, 4'b1000, 32'h8000_0000);
        rd(13'h030); chk("eisr_clr", 64'(last_rd), 64'h0);

        // Response, block gap and ADMA registers
        @(negedge CLK); resp_in = 32'hCAFE_F00D; resp_we = 1'b1;
        @(negedge CLK); resp_we = 1'b0;
        wr(13'h010, 4'hF, 32'h0);
        chk("resp_ro_err", 64'(last_err), 64'd0);
        rd(13'h010); chk("resp_val", 64'(last_rd), 64'hCAFE_F00D);
        wr(13'h028, 4'hF, 32'hABCD_1234);
        rd(13'h028); chk("bgc_rd", 64'(last_rd), 64'hABCD_0000);
        wr(13'h058, 4'b0101, 32'hDEAD_BEEF);
        wr(13'h05C, 4'hF, 32'h1234_5678);
        chk("adma_val", adma_addr, 64'h1234_5678_00AD_00EF);

        // Unmapped and misaligned accesses
        rd(13'h0FC); chk("unmap_err", 64'(last_err), 64'd1); chk("unmap_rd", 64'(last_rd), 64'h0);
        wr(13'h0FC, 4'hF, 32'hFFFF_FFFF); chk("unmap_wr_err", 64'(last_err), 64'd1);
        wr(13'h006, 4'hF, 32'hFFFF_FFFF); chk("misal_err", 64'(last_err), 64'd1);
        chk("misal_blk", 64'({blk_cnt, blk_size}), 64'h0003_0200);
        rd(13'h00A); chk("misal_rd", 64'(last_rd), 64'h0);

        // Reset coinciding with the accept edge of a write
        wr(13'h008, 4'hF, 32'h1111_1111);
        chk("arg_set", 64'(arg), 64'h1111_1111);
        @(negedge CLK);
        req = 1'b1; we = 1'b1; addrs = 13'h008; be = 4'hF; wr_data = 32'h5555_5555; rst_L = 1'b0;
        @(negedge CLK);
        chk("rst_noack", 64'(ack), 64'd0);
        req = 1'b0; we = 1'b0; rst_L = 1'b1;
        @(negedge CLK);
        chk("rst_noack2", 64'(ack), 64'd0);
        chk("rst_arg",    64'(arg), 64'h0);
        rd(13'h008); chk("rst_arg_rd", 64'(last_rd), 64'h0);

        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
